// File: rtl/aural_pkg.sv
// Shared definitions for the audio output-mode controller: mode indices,
// fade FSM encodings and the wrap-around mode stepping helpers.
package aural_pkg;

    localparam logic [2:0] MODE_STEREO = 3'd0;
    localparam logic [2:0] MODE_LEFT   = 3'd1;
    localparam logic [2:0] MODE_RIGHT  = 3'd2;
    localparam logic [2:0] MODE_MONO   = 3'd3;
    localparam logic [2:0] MODE_SWAP   = 3'd4;

    typedef enum logic [1:0] {
        FSM_IDLE     = 2'd0,
        FSM_FADE_OUT = 2'd1,
        FSM_FADE_IN  = 2'd2
    } fsm_t;

    function automatic logic [2:0] next_mode(input logic [2:0] m, input int unsigned num_modes);
        if ({29'd0, m} + 32'd1 >= num_modes) begin
            return 3'd0;
        end else begin
            return m + 3'd1;
        end
    endfunction

    function automatic logic [2:0] prev_mode(input logic [2:0] m, input int unsigned num_modes);
        if (m == 3'd0) begin
            return 3'(num_modes - 32'd1);
        end else begin
            return m - 3'd1;
        end
    endfunction

endpackage

// File: rtl/aural_gain_ramp.sv
// Saturating up/down gain counter for the crossfade; advances only when enabled
// (one step per consumed sample) and rests at full scale out of reset.
module aural_gain_ramp #(
    parameter int RAMP_SHIFT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    output logic [RAMP_SHIFT:0]   gain,
    output logic                  at_zero,
    output logic                  at_max
);

    localparam logic [RAMP_SHIFT:0] G_MAX  = {1'b1, {RAMP_SHIFT{1'b0}}};
    localparam logic [RAMP_SHIFT:0] G_ONE  = {{RAMP_SHIFT{1'b0}}, 1'b1};
    localparam logic [RAMP_SHIFT:0] G_ZERO = {(RAMP_SHIFT+1){1'b0}};

    logic [RAMP_SHIFT:0] gain_r;

    assign gain    = gain_r;
    assign at_zero = (gain_r == G_ZERO);
    assign at_max  = (gain_r == G_MAX);

    // Gain register: dir=1 counts up toward G_MAX, dir=0 down toward zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            gain_r <= G_MAX;
        end else if (en && dir && !at_max) begin
            gain_r <= gain_r + G_ONE;
        end else if (en && !dir && !at_zero) begin
            gain_r <= gain_r - G_ONE;
        end else begin
            gain_r <= gain_r;
        end
    end

endmodule

// File: rtl/aural_mode_ctrl.sv
// Output-mode selector with click-free mode changes: fades to silence, commits
// the new mode at zero gain, then fades back in. Applies mode and gain per sample.
module aural_mode_ctrl
    import aural_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int RAMP_SHIFT = 4,
    parameter int NUM_MODES  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        button_press,
    input  logic                        button_back,
    input  logic                        sample_ready,
    input  logic signed [SAMPLE_W-1:0]  sample_in_l,
    input  logic signed [SAMPLE_W-1:0]  sample_in_r,
    output logic signed [SAMPLE_W-1:0]  sample_out_l,
    output logic signed [SAMPLE_W-1:0]  sample_out_r,
    output logic [2:0]                  aural_state,
    output logic                        switching
);

    localparam int GW = RAMP_SHIFT + 1;
    localparam int PW = SAMPLE_W + RAMP_SHIFT + 2;
    localparam logic [GW-1:0] G_ONE    = {{RAMP_SHIFT{1'b0}}, 1'b1};
    localparam logic [GW-1:0] G_MAX_M1 = {1'b0, {RAMP_SHIFT{1'b1}}};

    fsm_t        state_r, state_s;
    logic [2:0]  mode_r, mode_s;
    logic [2:0]  pending_r, pending_s;
    logic [2:0]  step_base_s, stepped_s;
    logic        dwell_r, dwell_s;
    logic        switching_r;
    logic        step_s;
    logic        ramp_en_s, ramp_up_s;
    logic [GW-1:0] gain_s;
    logic        at_zero_s, at_max_s;

    logic signed [SAMPLE_W:0]   sum_s;
    logic signed [SAMPLE_W-1:0] map_l_s, map_r_s;
    logic signed [PW-1:0]       prod_l_s, prod_r_s;
    logic signed [SAMPLE_W-1:0] out_l_r, out_r_r;

    aural_gain_ramp #(.RAMP_SHIFT(RAMP_SHIFT)) u_ramp (
        .clk     (clk),
        .rst     (rst),
        .en      (ramp_en_s),
        .dir     (ramp_up_s),
        .gain    (gain_s),
        .at_zero (at_zero_s),
        .at_max  (at_max_s)
    );

    assign step_s = button_press ^ button_back;
    assign aural_state  = mode_r;
    assign switching    = switching_r;
    assign sample_out_l = out_l_r;
    assign sample_out_r = out_r_r;

    // Fade FSM: next state, pending/committed mode and ramp control.
    // dwell holds the ramp at zero for one extra sample right after the commit.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        pending_s   = pending_r;
        dwell_s     = dwell_r;
        ramp_en_s   = 1'b0;
        ramp_up_s   = 1'b0;
        step_base_s = (state_r == FSM_FADE_OUT) ? pending_r : mode_r;
        if (button_press) begin
            stepped_s = next_mode(step_base_s, NUM_MODES);
        end else begin
            stepped_s = prev_mode(step_base_s, NUM_MODES);
        end
        case (state_r)
            FSM_IDLE: begin
                if (step_s) begin
                    pending_s = stepped_s;
                    state_s   = FSM_FADE_OUT;
                end else begin
                    state_s   = FSM_IDLE;
                end
            end
            FSM_FADE_OUT: begin
                if (step_s) begin
                    pending_s = stepped_s;
                end else begin
                    pending_s = pending_r;
                end
                ramp_en_s = sample_ready;
                if (sample_ready && (gain_s <= G_ONE)) begin
                    mode_s  = pending_s;
                    state_s = FSM_FADE_IN;
                    dwell_s = 1'b1;
                end else begin
                    state_s = FSM_FADE_OUT;
                end
            end
            FSM_FADE_IN: begin
                if (step_s) begin
                    pending_s = stepped_s;
                    state_s   = FSM_FADE_OUT;
                    dwell_s   = 1'b0;
                    ramp_en_s = sample_ready;
                end else if (sample_ready) begin
                    if (dwell_r) begin
                        dwell_s = 1'b0;
                    end else begin
                        ramp_en_s = 1'b1;
                        ramp_up_s = 1'b1;
                        if (gain_s == G_MAX_M1) begin
                            state_s = FSM_IDLE;
                        end else begin
                            state_s = FSM_FADE_IN;
                        end
                    end
                end else begin
                    state_s = FSM_FADE_IN;
                end
            end
            default: begin
                state_s = FSM_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FSM_IDLE;
            mode_r      <= MODE_STEREO;
            pending_r   <= MODE_STEREO;
            dwell_r     <= 1'b0;
            switching_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            pending_r   <= pending_s;
            dwell_r     <= dwell_s;
            switching_r <= (state_s != FSM_IDLE);
        end
    end

    // Channel mapping; mono sums one bit wider so the average cannot overflow.
    always_comb begin
        sum_s = {sample_in_l[SAMPLE_W-1], sample_in_l} + {sample_in_r[SAMPLE_W-1], sample_in_r};
        case (mode_r)
            MODE_STEREO: begin map_l_s = sample_in_l;       map_r_s = sample_in_r;       end
            MODE_LEFT:   begin map_l_s = sample_in_l;       map_r_s = {SAMPLE_W{1'b0}};  end
            MODE_RIGHT:  begin map_l_s = {SAMPLE_W{1'b0}};  map_r_s = sample_in_r;       end
            MODE_MONO:   begin map_l_s = sum_s[SAMPLE_W:1]; map_r_s = sum_s[SAMPLE_W:1]; end
            MODE_SWAP:   begin map_l_s = sample_in_r;       map_r_s = sample_in_l;       end
            default:     begin map_l_s = sample_in_l;       map_r_s = sample_in_r;       end
        endcase
        prod_l_s = $signed({{(RAMP_SHIFT+2){map_l_s[SAMPLE_W-1]}}, map_l_s})
                 * $signed({{(SAMPLE_W+1){1'b0}}, gain_s});
        prod_r_s = $signed({{(RAMP_SHIFT+2){map_r_s[SAMPLE_W-1]}}, map_r_s})
                 * $signed({{(SAMPLE_W+1){1'b0}}, gain_s});
    end

    // Output sample registers, updated only when the codec takes a sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_l_r <= {SAMPLE_W{1'b0}};
            out_r_r <= {SAMPLE_W{1'b0}};
        end else if (sample_ready) begin
            out_l_r <= prod_l_s[RAMP_SHIFT +: SAMPLE_W];
            out_r_r <= prod_r_s[RAMP_SHIFT +: SAMPLE_W];
        end else begin
            out_l_r <= out_l_r;
            out_r_r <= out_r_r;
        end
    end

endmodule
